// File: rtl/time_set_ctrl_pkg.sv
// watch_pkg: shared FSM states, digit positions, per-position limits and BCD field helpers
package watch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT, ST_HOLD} state_t;
  localparam logic [2:0] POS_H_TEN = 3'd0;
  localparam logic [2:0] POS_H_ONE = 3'd1;
  localparam logic [2:0] POS_M_TEN = 3'd2;
  localparam logic [2:0] POS_M_ONE = 3'd3;
  localparam logic [2:0] POS_S_TEN = 3'd4;
  localparam logic [2:0] POS_S_ONE = 3'd5;
  localparam logic [3:0] LIM_H_TEN    = 4'd2;
  localparam logic [3:0] LIM_H_ONE    = 4'd9;
  localparam logic [3:0] LIM_H_ONE_20 = 4'd3;
  localparam logic [3:0] LIM_TEN      = 4'd5;
  localparam logic [3:0] LIM_ONE      = 4'd9;
  function automatic logic [3:0] get_digit(input logic [23:0] t, input logic [2:0] pos);
    return t[4*(5-int'(pos)) +: 4];
  endfunction
  function automatic logic [23:0] set_digit(input logic [23:0] t, input logic [2:0] pos, input logic [3:0] d);
    logic [23:0] r;
    r = t;
    r[4*(5-int'(pos)) +: 4] = d;
    return r;
  endfunction
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: keypad/time-counter/display signals of the time setter
interface time_set_ctrl_if;
  logic        set_mode;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic [23:0] cur_time;
  logic        load;
  logic [23:0] load_time;
  logic [23:0] edit_time;
  logic [2:0]  cursor;
  logic        blink;
  logic        busy;
  logic        err;
  modport master (output set_mode, key_valid, key_digit, cur_time,
                  input load, load_time, edit_time, cursor, blink, busy, err);
  modport slave  (input set_mode, key_valid, key_digit, cur_time,
                  output load, load_time, edit_time, cursor, blink, busy, err);
endinterface

// File: rtl/time_set_ctrl_limit.sv
// time_digit_limit: legality of a keyed digit at the cursor (range checks under TIME_SET_VALIDATE_EN)
module time_digit_limit
  import watch_pkg::*;
(
  input  logic [2:0] i_cursor,
  input  logic [3:0] i_digit,
  input  logic [3:0] i_h_ten,
  output logic       o_accept
);
`ifdef TIME_SET_VALIDATE_EN
  logic [3:0] w_lim;
  // pick the upper bound for the digit position; hour units shrink once the tens digit is 2
  always_comb w_lim = i_cursor == POS_H_TEN ? LIM_H_TEN :
                      i_cursor == POS_H_ONE ? (i_h_ten == 4'd2 ? LIM_H_ONE_20 : LIM_H_ONE) :
                      (i_cursor == POS_M_TEN || i_cursor == POS_S_TEN) ? LIM_TEN : LIM_ONE;
  assign o_accept = i_digit <= w_lim;
`else
  logic w_unused;
  assign w_unused = ^{i_cursor, i_h_ten};
  assign o_accept = i_digit <= 4'd9;
`endif
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad-driven HH:MM:SS entry and load sequencer; TIME_SET_VALIDATE_EN enables range checks and h_one clamp
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10000,
  parameter int BLINK_HALF  = 250
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int BW = $clog2(BLINK_HALF);
  state_t        r_state, w_next;
  logic [23:0]   r_buf, r_load_time, w_wbuf;
  logic [2:0]    r_cursor;
  logic [TW-1:0] r_to;
  logic [BW-1:0] r_bc;
  logic          r_blink, r_load, r_err, r_busy;
  logic [3:0]    w_h_ten;
  logic          w_accept, w_key, w_ok, w_bad, w_last, w_timeout, w_bc_wrap;
  assign w_h_ten   = get_digit(r_buf, POS_H_TEN);
  assign w_key     = r_state == ST_EDIT && bus.set_mode && bus.key_valid;
  assign w_ok      = w_key && w_accept;
  assign w_bad     = w_key && !w_accept;
  assign w_last    = r_cursor == POS_S_ONE;
  assign w_timeout = r_to == TW'(TIMEOUT_CYC - 1);
  assign w_bc_wrap = r_bc == BW'(BLINK_HALF - 1);
  time_digit_limit u_limit (
    .i_cursor (r_cursor),
    .i_digit  (bus.key_digit),
    .i_h_ten  (w_h_ten),
    .o_accept (w_accept)
  );
  // buffer image after writing the keyed digit, with the hour-units clamp when entering 2x
  always_comb begin
    w_wbuf = set_digit(r_buf, r_cursor, bus.key_digit);
`ifdef TIME_SET_VALIDATE_EN
    if (r_cursor == POS_H_TEN && bus.key_digit == 4'd2 && get_digit(r_buf, POS_H_ONE) > LIM_H_ONE_20)
      w_wbuf = set_digit(w_wbuf, POS_H_ONE, 4'd0);
`endif
  end
  // next state: abort beats a key, an accepted key beats timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = bus.set_mode ? ST_EDIT : ST_IDLE;
      ST_EDIT:   w_next = !bus.set_mode ? ST_IDLE : w_ok ? (w_last ? ST_COMMIT : ST_EDIT) : w_timeout ? ST_IDLE : ST_EDIT;
      ST_COMMIT: w_next = ST_HOLD;
      ST_HOLD:   w_next = bus.set_mode ? ST_HOLD : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  // edit buffer, cursor, timers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf       <= '0;
      r_load_time <= '0;
      r_cursor    <= '0;
      r_to        <= '0;
      r_bc        <= '0;
      r_blink     <= 1'b0;
      r_load      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_load <= w_ok && w_last;
      r_err  <= w_bad;
      r_busy <= w_next != ST_IDLE;
      if (r_state == ST_IDLE && bus.set_mode) begin
        r_buf    <= bus.cur_time;
        r_cursor <= POS_H_TEN;
        r_to     <= '0;
        r_bc     <= '0;
        r_blink  <= 1'b1;
      end else if (w_ok) begin
        r_buf    <= w_wbuf;
        r_cursor <= w_last ? r_cursor : r_cursor + 3'd1;
        r_to     <= '0;
        r_bc     <= '0;
        r_blink  <= 1'b1;
        if (w_last) r_load_time <= w_wbuf;
      end else if (r_state == ST_EDIT) begin
        r_to    <= r_to + TW'(1);
        r_bc    <= w_bc_wrap ? '0 : r_bc + BW'(1);
        r_blink <= r_blink ^ w_bc_wrap;
      end
      if (w_next != ST_EDIT) r_blink <= 1'b0;
    end
  end
  assign bus.load      = r_load;
  assign bus.load_time = r_load_time;
  assign bus.edit_time = r_buf;
  assign bus.cursor    = r_cursor;
  assign bus.blink     = r_blink;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_load = 0;
  time_set_ctrl_if bus();
  time_set_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.load === 1'b1) n_load++;
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic key(input logic [3:0] d);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask
  task automatic enter(input logic [23:0] t);
    @(negedge clk);
    bus.cur_time = t;
    bus.set_mode = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    bus.set_mode  = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.cur_time  = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 24'(bus.busy), 24'd0);
    chk("rst_load", 24'(bus.load), 24'd0);
    chk("rst_err", 24'(bus.err), 24'd0);
    chk("rst_blink", 24'(bus.blink), 24'd0);
    chk("rst_cursor", 24'(bus.cursor), 24'd0);
    chk("rst_edit", bus.edit_time, 24'h0);
    chk("rst_ltime", bus.load_time, 24'h0);
    rst = 1'b1;
    // full entry 12:34:56 -> 23:59:07
    enter(24'h123456);
    chk("ent_busy", 24'(bus.busy), 24'd1);
    chk("ent_edit", bus.edit_time, 24'h123456);
    chk("ent_cursor", 24'(bus.cursor), 24'd0);
    chk("ent_blink", 24'(bus.blink), 24'd1);
    key(4'd2); chk("k1_edit", bus.edit_time, 24'h223456); chk("k1_cur", 24'(bus.cursor), 24'd1);
    key(4'd3); chk("k2_edit", bus.edit_time, 24'h233456); chk("k2_cur", 24'(bus.cursor), 24'd2);
    key(4'd5); chk("k3_edit", bus.edit_time, 24'h235456); chk("k3_cur", 24'(bus.cursor), 24'd3);
    key(4'd9); chk("k4_edit", bus.edit_time, 24'h235956); chk("k4_cur", 24'(bus.cursor), 24'd4);
    key(4'd0); chk("k5_edit", bus.edit_time, 24'h235906); chk("k5_cur", 24'(bus.cursor), 24'd5);
    chk("k5_noload", 24'(bus.load), 24'd0);
    key(4'd7);
    chk("k6_edit", bus.edit_time, 24'h235907);
    chk("k6_load", 24'(bus.load), 24'd1);
    chk("k6_ltime", bus.load_time, 24'h235907);
    chk("k6_blink", 24'(bus.blink), 24'd0);
    @(negedge clk);
    chk("hold_load", 24'(bus.load), 24'd0);
    repeat (5) @(negedge clk);
    chk("hold_busy", 24'(bus.busy), 24'd1);
    bus.set_mode = 1'b0;
    @(negedge clk);
    chk("idle_busy", 24'(bus.busy), 24'd0);
    chk("idle_ltime", bus.load_time, 24'h235907);
    chk("one_load", 24'(n_load), 24'd1);
    // rejected keys
    enter(24'h190000);
    key(4'd12);
    chk("e12_err", 24'(bus.err), 24'd1);
    chk("e12_cur", 24'(bus.cursor), 24'd0);
    chk("e12_edit", bus.edit_time, 24'h190000);
    @(negedge clk);
    chk("err_pulse", 24'(bus.err), 24'd0);
`ifdef TIME_SET_VALIDATE_EN
    key(4'd3);
    chk("e3_err", 24'(bus.err), 24'd1);
    chk("e3_cur", 24'(bus.cursor), 24'd0);
    key(4'd2);
    chk("clamp_edit", bus.edit_time, 24'h200000);
    chk("clamp_err", 24'(bus.err), 24'd0);
    key(4'd4);
    chk("e4_err", 24'(bus.err), 24'd1);
    chk("e4_cur", 24'(bus.cursor), 24'd1);
    chk("e4_edit", bus.edit_time, 24'h200000);
`else
    key(4'd2);
    chk("noclamp_edit", bus.edit_time, 24'h290000);
    chk("noclamp_err", 24'(bus.err), 24'd0);
`endif
    key(4'd15);
    chk("e15_err", 24'(bus.err), 24'd1);
    chk("e15_cur", 24'(bus.cursor), 24'd1);
    bus.set_mode = 1'b0;
    @(negedge clk);
    chk("err_abort_busy", 24'(bus.busy), 24'd0);
    chk("err_noload", 24'(n_load), 24'd1);
    // timeout after 1,2 with blink toggle
    enter(24'h000000);
    key(4'd1);
    key(4'd2);
    chk("to_edit", bus.edit_time, 24'h120000);
    repeat (249) @(negedge clk);
    chk("blink_hi", 24'(bus.blink), 24'd1);
    @(negedge clk);
    chk("blink_lo", 24'(bus.blink), 24'd0);
    repeat (9749) @(negedge clk);
    chk("to_busy_pre", 24'(bus.busy), 24'd1);
    @(negedge clk);
    chk("to_busy", 24'(bus.busy), 24'd0);
    chk("to_blink", 24'(bus.blink), 24'd0);
    chk("to_noload", 24'(n_load), 24'd1);
    bus.set_mode = 1'b0;
    // abort coinciding with fourth key
    enter(24'h000000);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    chk("ab_edit3", bus.edit_time, 24'h123000);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd4;
    bus.set_mode  = 1'b0;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("ab_busy", 24'(bus.busy), 24'd0);
    chk("ab_edit", bus.edit_time, 24'h123000);
    chk("ab_err", 24'(bus.err), 24'd0);
    chk("ab_noload", 24'(n_load), 24'd1);
    // asynchronous reset mid-entry
    enter(24'h080000);
    key(4'd1);
    key(4'd1);
    chk("pre_rst_edit", bus.edit_time, 24'h110000);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 24'(bus.busy), 24'd0);
    chk("arst_cursor", 24'(bus.cursor), 24'd0);
    chk("arst_edit", bus.edit_time, 24'h0);
    chk("arst_ltime", bus.load_time, 24'h0);
    chk("arst_blink", 24'(bus.blink), 24'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rerun_busy", 24'(bus.busy), 24'd1);
    chk("rerun_edit", bus.edit_time, 24'h080000);
    chk("rerun_cursor", 24'(bus.cursor), 24'd0);
    chk("rst_noload", 24'(n_load), 24'd1);
    bus.set_mode = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
